// File: rtl/cr_kme_fifo_pkg.sv
// cr_kme_fifo_pkg: shared types and constants for the cr_kme fifo read-side skid endpoint
package cr_kme_fifo_pkg;
    typedef enum logic [1:0] {IDLE, FLUSH, DONE} fsm_e;
    localparam int SKID_DEPTH = 2;
    typedef logic [1:0] occ_t;
endpackage

// File: rtl/cr_kme_skid2.sv
// cr_kme_skid2: two-entry order-preserving holding buffer; entry0 is the head
module cr_kme_skid2
    import cr_kme_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output occ_t                  occ_o
);
    logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    occ_t                  occ_q, occ_d, wr_idx;

    // Pop shifts entry1 forward first; a push then lands in the first free slot.
    always_comb begin
        wr_idx = occ_q - occ_t'(pop_i);
        e0_d   = (push_i && wr_idx == 2'd0) ? data_i : (pop_i ? e1_q : e0_q);
        e1_d   = (push_i && wr_idx == 2'd1) ? data_i : e1_q;
        occ_d  = clear_i ? '0 : occ_q + occ_t'(push_i) - occ_t'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) occ_q <= occ_t'(SKID_DEPTH));

    assign data_o = e0_q;
    assign occ_o  = occ_q;
endmodule

// File: rtl/cr_kme_fifo_rd_skid.sv
// cr_kme_fifo_rd_skid: pops a cr_kme fifo via valid/ack and re-presents words through a
// 2-entry skid buffer, with flush sequencing, handshake checking and a forwarded-word count.
module cr_kme_fifo_rd_skid
    import cr_kme_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_out,
    input  logic                  fifo_out_valid,
    output logic                  fifo_out_ack,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_stall,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  protocol_err,
    output logic [CNT_WIDTH-1:0]  fwd_count
);
    fsm_e                  state_q;
    occ_t                  occ;
    logic                  idle, xfer, pop;
    logic                  done_q, err_q, prev_valid_q, prev_ack_q;
    logic [DATA_WIDTH-1:0] prev_data_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    assign idle         = state_q == IDLE;
    assign out_valid    = idle && occ != '0;
    assign xfer         = out_valid && !out_stall;
    assign fifo_out_ack = fifo_out_valid && ((idle && occ < occ_t'(SKID_DEPTH)) || state_q == FLUSH);
    assign pop          = fifo_out_valid && fifo_out_ack;

    cr_kme_skid2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pop && idle),
        .pop_i   (xfer),
        .clear_i (idle && flush),
        .data_i  (fifo_out),
        .data_o  (out_data),
        .occ_o   (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_ack_q   <= 1'b0;
            prev_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE:    if (flush) state_q <= FLUSH;
                FLUSH:   if (!fifo_out_valid) state_q <= DONE;
                default: state_q <= IDLE;
            endcase
            done_q       <= state_q == FLUSH && !fifo_out_valid;
            // A word offered but not taken must stay put, unchanged, until acked.
            err_q        <= prev_valid_q && !prev_ack_q && (!fifo_out_valid || fifo_out != prev_data_q);
            prev_valid_q <= fifo_out_valid;
            prev_ack_q   <= fifo_out_ack;
            prev_data_q  <= fifo_out;
            if (xfer && cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign flush_done   = done_q;
    assign protocol_err = err_q;
    assign fwd_count    = cnt_q;
endmodule

// File: tb/tb_cr_kme_fifo_rd_skid.sv
// tb_cr_kme_fifo_rd_skid: fifo model + scoreboard monitor around the skid endpoint
module tb_cr_kme_fifo_rd_skid;
    localparam int DW = 8;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] fifo_out = '0;
    logic          fifo_out_valid = 1'b0, out_stall = 1'b0, flush = 1'b0;
    logic          fifo_out_ack, out_valid, flush_done, protocol_err;
    logic [DW-1:0] out_data;
    logic [15:0]   fwd_count;
    logic          ack_b, out_valid_b, flush_done_b, err_b;
    logic [DW-1:0] out_data_b;
    logic [3:0]    fwd_count_b;

    int passed = 0, total = 0, ack_cnt = 0, pop_total = 0, xfer_total = 0;
    bit force_low = 1'b0;
    logic [DW-1:0] fifo_q[$], exp_q[$];

    cr_kme_fifo_rd_skid #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid),
        .fifo_out_ack(fifo_out_ack), .out_data(out_data), .out_valid(out_valid),
        .out_stall(out_stall), .flush(flush), .flush_done(flush_done),
        .protocol_err(protocol_err), .fwd_count(fwd_count)
    );

    cr_kme_fifo_rd_skid #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid),
        .fifo_out_ack(ack_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_stall(out_stall), .flush(flush), .flush_done(flush_done_b),
        .protocol_err(err_b), .fwd_count(fwd_count_b)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    endfunction

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(logic [DW-1:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
    endtask

    // Fifo model: presents head on negedge, pops when acked just before the rising edge.
    initial forever begin
        @(negedge clk);
        fifo_out_valid = !force_low && fifo_q.size() != 0;
        if (fifo_q.size() != 0) fifo_out = fifo_q[0];
        #4;
        if (fifo_out_valid && fifo_out_ack && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            ack_cnt++;
            pop_total++;
        end
    end

    // Scoreboard monitor: every downstream transfer must match the oldest expected word.
    initial forever begin
        @(negedge clk);
        #4;
        if (out_valid && !out_stall) begin
            xfer_total++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL xfer_unexpected: got word %0d, required no transfer", out_data);
            end else chk("xfer_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int max_occ, occ_now, p0, x0, c0, done_cnt, err_cnt;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_fwd_count", 32'(fwd_count), 0);
        chk("rst_flush_done", 32'(flush_done), 0);
        chk("rst_protocol_err", 32'(protocol_err), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // 1: back-to-back stream, one-cycle pop-to-output latency
        push(0); push(1); push(1); push(0);
        tick(1);
        chk("t1_latency_valid", 32'(out_valid), 1);
        chk("t1_latency_data", 32'(out_data), 0);
        tick(4);
        chk("t1_fwd_count", 32'(fwd_count), 4);
        chk("t1_idle_valid", 32'(out_valid), 0);

        // 2: stalled downstream takes exactly two words
        out_stall = 1'b1;
        ack_cnt = 0;
        for (int i = 10; i < 15; i++) push(DW'(i));
        tick(6);
        chk("t2_ack_cnt", 32'(ack_cnt), 2);
        chk("t2_fifo_left", 32'(fifo_q.size()), 3);
        chk("t2_ack_low", 32'(fifo_out_ack), 0);
        chk("t2_head", 32'(out_data), 10);
        out_stall = 1'b0;
        tick(10);
        chk("t2_drained", 32'(exp_q.size()), 0);
        chk("t2_fwd_count", 32'(fwd_count), 9);

        // 3: random backpressure over 1000 words
        max_occ = 0;
        p0 = pop_total;
        x0 = xfer_total;
        for (int i = 0; i < 1000; i++) push(DW'($urandom));
        for (int c = 0; c < 20000 && exp_q.size() != 0; c++) begin
            out_stall = 1'($urandom_range(0, 1));
            tick(1);
            occ_now = (pop_total - p0) - (xfer_total - x0);
            if (occ_now > max_occ) max_occ = occ_now;
        end
        out_stall = 1'b0;
        tick(2);
        chk("t3_drained", 32'(exp_q.size()), 0);
        chk("t3_max_occ", 32'(max_occ), 2);
        chk("t3_fwd_count", 32'(fwd_count), 1009);
        chk("t3_fwd_count_sat", 32'(fwd_count_b), 15);

        // 4: flush with a full buffer and three words waiting
        out_stall = 1'b1;
        for (int i = 20; i < 25; i++) push(DW'(i));
        tick(5);
        chk("t4_fifo_pre", 32'(fifo_q.size()), 3);
        chk("t4_valid_pre", 32'(out_valid), 1);
        c0 = int'(fwd_count);
        ack_cnt = 0;
        flush = 1'b1;
        exp_q.delete();
        tick(1);
        flush = 1'b0;
        out_stall = 1'b0;
        chk("t4_valid_low", 32'(out_valid), 0);
        done_cnt = 0;
        repeat (8) begin
            tick(1);
            done_cnt += int'(flush_done);
        end
        chk("t4_done_pulses", 32'(done_cnt), 1);
        chk("t4_acks", 32'(ack_cnt), 3);
        chk("t4_fifo_empty", 32'(fifo_q.size()), 0);
        chk("t4_fwd_count", 32'(fwd_count), 32'(c0));

        // 5: valid withdrawn without ack, then data changed without ack
        out_stall = 1'b1;
        push(30); push(31); push(32);
        tick(4);
        chk("t5_fifo_held", 32'(fifo_q.size()), 1);
        chk("t5_no_err", 32'(protocol_err), 0);
        force_low = 1'b1;
        tick(1);
        chk("t5_err_valid_drop", 32'(protocol_err), 1);
        err_cnt = 0;
        repeat (3) begin
            tick(1);
            err_cnt += int'(protocol_err);
        end
        chk("t5_err_once", 32'(err_cnt), 0);
        force_low = 1'b0;
        tick(2);
        fifo_q[0] = 33;
        exp_q[2] = 33;
        tick(1);
        chk("t5_err_data_change", 32'(protocol_err), 1);
        tick(1);
        chk("t5_err_clear", 32'(protocol_err), 0);
        out_stall = 1'b0;
        tick(6);
        chk("t5_drained", 32'(exp_q.size()), 0);

        // 6: asynchronous reset with a full buffer
        out_stall = 1'b1;
        for (int i = 40; i < 44; i++) push(DW'(i));
        tick(4);
        chk("t6_fifo_pre", 32'(fifo_q.size()), 2);
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        #1;
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_out_data", 32'(out_data), 0);
        chk("t6_fwd_count", 32'(fwd_count), 0);
        chk("t6_fwd_count_b", 32'(fwd_count_b), 0);
        chk("t6_flush_done", 32'(flush_done), 0);
        chk("t6_protocol_err", 32'(protocol_err), 0);
        tick(2);
        out_stall = 1'b0;
        rst_n = 1'b1;
        tick(1);

        // 7: traffic after reset, narrow counter saturates
        for (int i = 0; i < 20; i++) push(DW'(i * 3 + 1));
        tick(30);
        chk("t7_drained", 32'(exp_q.size()), 0);
        chk("t7_fwd_count", 32'(fwd_count), 20);
        chk("t7_fwd_count_sat", 32'(fwd_count_b), 15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
